muldiv_sched: RTL and testbench
===============================

# muldiv_sched

Sequencer and arbiter for the shared iterative multiply/divide unit and owner of the architectural HI/LO registers. It sits in EX beside the ALU, accepts up to two mul/div/HI-LO-move requests per bundle (slot0 older than slot1), and runs them through the single unit in program order. It holds the pipeline with `stall_req` until the whole bundle has completed.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `flush`  in  1  cancel current bundle
- `req0_valid` / `req1_valid`  in  1  slot request valid
- `req0_op` / `req1_op`  in  6  ALU_SEL code
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  32  operands
- `md_en`  out  1  unit enable, held high until `md_ready`
- `md_is_div`  out  1  1 = divider, 0 = multiplier
- `md_sign`  out  1  signed op
- `md_a`, `md_b`  out  32  unit operands
- `md_ready`  in  1  unit result valid, 1-cycle pulse
- `md_hi`, `md_lo`  in  32  unit result (remainder/quotient or product high/low)
- `stall_req`  out  1  hold the bundle
- `hi`, `lo`  out  32  architectural HI/LO
- `mul_res0`, `mul_res1`  out  32  low-product result for ALU_SEL_MUL per slot, registered

## Operation
- Multi-cycle ("mc") ops: DIV, DIVU, MULT, MULTU, MUL. Single-cycle ops: MTHI, MTLO. All other codes are ignored.
- Sign: DIV, MULT and MUL are signed. `md_is_div` is 1 for DIV and DIVU.
- FSM states:
  - IDLE: if slot0 is mc → BUSY0; else if slot1 is mc → BUSY1.
  - BUSY0: on `md_ready`, go to GAP if slot1 is mc, else DONE.
  - GAP → BUSY1.
  - BUSY1: on `md_ready` → DONE.
  - DONE → IDLE.
- `md_en` = 1 only in BUSY0/BUSY1. The operands are those of the active slot; they are driven from `req*` while `md_en` is high.
- GAP guarantees `md_en` is low for ≥1 cycle between back-to-back ops, so the unit restarts.
- Result write on the `md_ready` cycle:
  - DIV/DIVU/MULT/MULTU: HI←`md_hi`, LO←`md_lo`.
  - MUL: `mul_resN`←`md_lo`; HI/LO untouched.
- `stall_req` = IDLE & (any valid mc op), or BUSY0, GAP, BUSY1. It is 0 in DONE and in IDLE with no mc op. The bundle advances at the end of a stall-low cycle.
- MTHI/MTLO apply only in a stall-low cycle (the commit cycle), with order slot0 then slot1, so slot1 wins on the same register.
- A slot0 MTHI/MTLO is suppressed when slot1 is DIV/DIVU/MULT/MULTU; the later op overwrites it.
- `flush`=1 in any state:
  - next state IDLE, `md_en` low next cycle;
  - the same-cycle `md_ready` write is discarded;
  - same-cycle MTHI/MTLO are suppressed;
  - earlier committed HI/LO writes are retained.
- Requests are required stable while `stall_req`=1. The block does not re-latch operands.

## Timing
- Reset values (`rst`=0 at a clock edge): state IDLE; `hi`=`lo`=`mul_res0`=`mul_res1`=0; `md_en`=0; `md_sign`=`md_is_div`=0; `md_a`=`md_b`=0. `stall_req`=0 in the reset cycle regardless of requests.
- Single mc op, unit latency L cycles from `md_en` rise to `md_ready`: stall is high for L+1 cycles (IDLE, BUSY0…); HI/LO update at the `md_ready` edge; DONE is stall-low.
- Two mc ops: stall is high for L0 + 1 + L1 + 1 cycles, i.e. IDLE, BUSY0, GAP, BUSY1.
- MTHI/MTLO alone: zero stall; write at the edge of the request cycle.
- `md_ready` outside BUSY0/BUSY1 is ignored.
- `hi`/`lo` are registers; a write is visible the cycle after the write edge.

## Structure
- Op codes: the shared ALU_SEL_* definitions from the decode define file; do not duplicate them.
- FSM state encodings and the op-class decode functions (is_mc, is_div, is_signed, writes_hilo): local to this block or in that define file; no new package.
- One natural sub-module: `hilo_regs`. It holds the HI/LO registers with independent write enables and a synchronous active-low reset.

## Test plan
- Reset: hold `rst`=0 with `req0` MULT valid → `stall_req`=0, `hi`=`lo`=0, `md_en`=0.
- Slot0 MULT 0xFFFFFFFF×2 (signed), unit model L=4 → stall high for 5 cycles; `md_sign`=1, `md_is_div`=0; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- Slot0 DIVU 100/7, slot1 MUL 3×5 → GAP shows `md_en`=0 for exactly 1 cycle; `hi`=2, `lo`=14, `mul_res1`=15; `hi`/`lo` unchanged by the MUL.
- Slot0 MTHI 0xA, slot1 MTLO 0xB, no mc op → no stall; next cycle `hi`=0xA, `lo`=0xB.
- Slot0 MTHI 0x1, slot1 DIV −7/2 → MTHI suppressed; `hi`=0xFFFFFFFF (−1), `lo`=0xFFFFFFFD (−3).
- Flush in BUSY1 coincident with `md_ready` → `hi`/`lo` keep slot0's results, state IDLE next cycle, `md_en`=0.

Source files
------------

// File: rtl/muldiv_sched_pkg.sv
// Shared ALU_SEL op codes, scheduler state encoding and op-class decode helpers
// for the multiply/divide sequencer.
package muldiv_sched_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 6;

    typedef logic [OP_W-1:0] alu_sel_t;

    localparam alu_sel_t ALU_SEL_NOP   = 6'h00;
    localparam alu_sel_t ALU_SEL_ADD   = 6'h01;
    localparam alu_sel_t ALU_SEL_MTHI  = 6'h11;
    localparam alu_sel_t ALU_SEL_MTLO  = 6'h13;
    localparam alu_sel_t ALU_SEL_MULT  = 6'h18;
    localparam alu_sel_t ALU_SEL_MULTU = 6'h19;
    localparam alu_sel_t ALU_SEL_DIV   = 6'h1a;
    localparam alu_sel_t ALU_SEL_DIVU  = 6'h1b;
    localparam alu_sel_t ALU_SEL_MUL   = 6'h1c;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BUSY0 = 3'd1,
        ST_GAP   = 3'd2,
        ST_BUSY1 = 3'd3,
        ST_DONE  = 3'd4
    } md_state_t;

    function automatic logic is_mc(input alu_sel_t op);
        return op inside {ALU_SEL_DIV, ALU_SEL_DIVU, ALU_SEL_MULT, ALU_SEL_MULTU, ALU_SEL_MUL};
    endfunction

    function automatic logic is_div(input alu_sel_t op);
        return op inside {ALU_SEL_DIV, ALU_SEL_DIVU};
    endfunction

    function automatic logic is_signed(input alu_sel_t op);
        return op inside {ALU_SEL_DIV, ALU_SEL_MULT, ALU_SEL_MUL};
    endfunction

    // mc ops whose result lands in HI/LO (MUL goes to the slot result instead)
    function automatic logic writes_hilo(input alu_sel_t op);
        return op inside {ALU_SEL_DIV, ALU_SEL_DIVU, ALU_SEL_MULT, ALU_SEL_MULTU};
    endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// Request bundle from issue plus the handshake to the shared mul/div unit.
interface muldiv_sched_if;
    import muldiv_sched_pkg::*;

    logic            req0_valid;
    logic            req1_valid;
    alu_sel_t        req0_op;
    alu_sel_t        req1_op;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;

    logic            md_en;
    logic            md_is_div;
    logic            md_sign;
    logic [XLEN-1:0] md_a;
    logic [XLEN-1:0] md_b;
    logic            md_ready;
    logic [XLEN-1:0] md_hi;
    logic [XLEN-1:0] md_lo;

    // scheduler side
    modport master (
        input  req0_valid, req1_valid, req0_op, req1_op,
        input  req0_a, req0_b, req1_a, req1_b,
        input  md_ready, md_hi, md_lo,
        output md_en, md_is_div, md_sign, md_a, md_b
    );

    // issue stage + arithmetic unit side
    modport slave (
        output req0_valid, req1_valid, req0_op, req1_op,
        output req0_a, req0_b, req1_a, req1_b,
        output md_ready, md_hi, md_lo,
        input  md_en, md_is_div, md_sign, md_a, md_b
    );

endinterface

// File: rtl/muldiv_sched_hilo_regs.sv
// Architectural HI/LO registers with independent write enables.
module hilo_regs
    import muldiv_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] hi_d,
    input  logic [XLEN-1:0] lo_d,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_d;
            if (lo_we) lo <= lo_d;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// Runs up to two mul/div/HI-LO-move requests of a bundle through the single
// iterative unit in program order, stalling the bundle until all complete.
module muldiv_sched
    import muldiv_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    muldiv_sched_if.master  bus,
    output logic            stall_req,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] mul_res0,
    output logic [XLEN-1:0] mul_res1
);

    md_state_t state;
    md_state_t state_nxt;

    logic            mc0;
    logic            mc1;
    logic            stall;
    logic            en;
    logic            act1;
    alu_sel_t        act_op;
    logic            md_wr;
    logic            hilo_wr;
    logic            commit;
    logic            mt0_ok;
    logic            mt0_hi;
    logic            mt0_lo;
    logic            mt1_hi;
    logic            mt1_lo;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;

    assign mc0 = bus.req0_valid && is_mc(bus.req0_op);
    assign mc1 = bus.req1_valid && is_mc(bus.req1_op);

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Sequencing: slot0 first, a one-cycle GAP drops md_en so the unit restarts.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        en        = 1'b0;
        act1      = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = mc0 || mc1;
                if (mc0)      state_nxt = ST_BUSY0;
                else if (mc1) state_nxt = ST_BUSY1;
            end
            ST_BUSY0: begin
                stall = 1'b1;
                en    = 1'b1;
                if (bus.md_ready) state_nxt = mc1 ? ST_GAP : ST_DONE;
            end
            ST_GAP: begin
                stall     = 1'b1;
                state_nxt = ST_BUSY1;
            end
            ST_BUSY1: begin
                stall = 1'b1;
                en    = 1'b1;
                act1  = 1'b1;
                if (bus.md_ready) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    assign stall_req = rst && stall;

    assign act_op        = act1 ? bus.req1_op : bus.req0_op;
    assign bus.md_en     = en;
    assign bus.md_is_div = en && is_div(act_op);
    assign bus.md_sign   = en && is_signed(act_op);
    assign bus.md_a      = en ? (act1 ? bus.req1_a : bus.req0_a) : '0;
    assign bus.md_b      = en ? (act1 ? bus.req1_b : bus.req0_b) : '0;

    // Unit result capture; md_ready outside a BUSY state is ignored via en.
    assign md_wr   = en && bus.md_ready && !flush;
    assign hilo_wr = md_wr && writes_hilo(act_op);

    // HI/LO moves commit only when the bundle advances; slot1 wins on conflict.
    assign commit = !stall_req && !flush && rst;
    assign mt0_ok = commit && bus.req0_valid && !(mc1 && writes_hilo(bus.req1_op));
    assign mt0_hi = mt0_ok && (bus.req0_op == ALU_SEL_MTHI);
    assign mt0_lo = mt0_ok && (bus.req0_op == ALU_SEL_MTLO);
    assign mt1_hi = commit && bus.req1_valid && (bus.req1_op == ALU_SEL_MTHI);
    assign mt1_lo = commit && bus.req1_valid && (bus.req1_op == ALU_SEL_MTLO);

    assign hi_we = hilo_wr || mt0_hi || mt1_hi;
    assign lo_we = hilo_wr || mt0_lo || mt1_lo;
    assign hi_d  = hilo_wr ? bus.md_hi : (mt1_hi ? bus.req1_a : bus.req0_a);
    assign lo_d  = hilo_wr ? bus.md_lo : (mt1_lo ? bus.req1_a : bus.req0_a);

    hilo_regs u_hilo_regs (
        .clk   (clk),
        .rst   (rst),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .hi_d  (hi_d),
        .lo_d  (lo_d),
        .hi    (hi),
        .lo    (lo)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            mul_res0 <= '0;
            mul_res1 <= '0;
        end else begin
            if (md_wr && !act1 && (act_op == ALU_SEL_MUL)) mul_res0 <= bus.md_lo;
            if (md_wr &&  act1 && (act_op == ALU_SEL_MUL)) mul_res1 <= bus.md_lo;
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized self-checking bench for muldiv_sched with a latency-programmable
// unit model and a program-order reference model of HI/LO and MUL results.
module tb_muldiv_sched;
    import muldiv_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall_req;
    logic [31:0] hi, lo, mul_res0, mul_res1;

    muldiv_sched_if bus ();

    muldiv_sched dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.master),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .mul_res0  (mul_res0),
        .mul_res1  (mul_res1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int unit_lat = 4;
    int unit_cnt = 0;

    // reference architectural state
    logic [31:0] exp_hi = '0, exp_lo = '0, exp_mr0 = '0, exp_mr1 = '0;

    // results of the last run_bundle
    int   r_stall, r_en_low, r_ok;
    logic r_sign, r_div;

    function automatic void calc(input logic dv, input logic sg, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        if (dv) begin
            if (b == 0) begin
                h = a; l = '1;
            end else if (sg) begin
                h = 32'($signed(a) % $signed(b));
                l = 32'($signed(a) / $signed(b));
            end else begin
                h = a % b;
                l = a / b;
            end
        end else begin
            if (sg) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            else    p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end
    endfunction

    // Iterative unit: result valid in the L-th cycle of a continuous md_en run.
    always @(posedge clk) begin
        logic [31:0] h, l;
        #1;
        if (bus.md_en === 1'b1) begin
            unit_cnt++;
            if (unit_cnt == unit_lat) begin
                calc(bus.md_is_div, bus.md_sign, bus.md_a, bus.md_b, h, l);
                bus.md_hi    = h;
                bus.md_lo    = l;
                bus.md_ready = 1'b1;
            end else begin
                bus.md_hi    = $urandom;
                bus.md_lo    = $urandom;
                bus.md_ready = 1'b0;
            end
        end else begin
            unit_cnt     = 0;
            bus.md_hi    = $urandom;
            bus.md_lo    = $urandom;
            bus.md_ready = 1'b0;
        end
    end

    function automatic logic tb_mc(input alu_sel_t op);
        case (op)
            ALU_SEL_MULT, ALU_SEL_MULTU, ALU_SEL_DIV, ALU_SEL_DIVU, ALU_SEL_MUL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Program-order architectural effect of one slot.
    task automatic ref_apply(input int slot, input logic v, input alu_sel_t op,
                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] h, l;
        if (!v) return;
        case (op)
            ALU_SEL_MULT:  begin calc(1'b0, 1'b1, a, b, h, l); exp_hi = h; exp_lo = l; end
            ALU_SEL_MULTU: begin calc(1'b0, 1'b0, a, b, h, l); exp_hi = h; exp_lo = l; end
            ALU_SEL_DIV:   begin calc(1'b1, 1'b1, a, b, h, l); exp_hi = h; exp_lo = l; end
            ALU_SEL_DIVU:  begin calc(1'b1, 1'b0, a, b, h, l); exp_hi = h; exp_lo = l; end
            ALU_SEL_MUL: begin
                calc(1'b0, 1'b1, a, b, h, l);
                if (slot == 0) exp_mr0 = l; else exp_mr1 = l;
            end
            ALU_SEL_MTHI: exp_hi = a;
            ALU_SEL_MTLO: exp_lo = a;
            default: ;
        endcase
    endtask

    function automatic int exp_stall(input logic m0, input logic m1, input int lat);
        if (m0 && m1) return 2 * lat + 2;
        if (m0 || m1) return lat + 1;
        return 0;
    endfunction

    task automatic clear_req();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_op = ALU_SEL_NOP; bus.req1_op = ALU_SEL_NOP;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    endtask

    // Present a bundle, hold it while stalled, release it after the commit edge.
    task automatic run_bundle(input logic v0, input alu_sel_t op0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic v1, input alu_sel_t op1, input logic [31:0] a1, input logic [31:0] b1,
                              input int lat);
        logic seen_en;
        @(negedge clk);
        unit_lat = lat;
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        r_stall = 0; r_en_low = 0; r_ok = 0; r_sign = 1'b0; r_div = 1'b0; seen_en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (stall_req !== 1'b1) begin
                r_ok = 1;
                break;
            end
            r_stall++;
            if (bus.md_en !== 1'b1) r_en_low++;
            else if (!seen_en) begin
                seen_en = 1'b1;
                r_sign  = bus.md_sign;
                r_div   = bus.md_is_div;
            end
            @(negedge clk);
        end
        @(negedge clk);
        clear_req();
        #1;
        total++;
        if (r_ok != 1) begin
            bad++;
            $display("FAIL bundle_timeout stall never released after %0d cycles", r_stall);
        end
    endtask

    task automatic check_arch(input string tag);
        total++;
        if (hi !== exp_hi) begin bad++; $display("FAIL %s_hi got=%h exp=%h", tag, hi, exp_hi); end
        total++;
        if (lo !== exp_lo) begin bad++; $display("FAIL %s_lo got=%h exp=%h", tag, lo, exp_lo); end
        total++;
        if (mul_res0 !== exp_mr0) begin bad++; $display("FAIL %s_mr0 got=%h exp=%h", tag, mul_res0, exp_mr0); end
        total++;
        if (mul_res1 !== exp_mr1) begin bad++; $display("FAIL %s_mr1 got=%h exp=%h", tag, mul_res1, exp_mr1); end
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        clear_req();
        bus.req0_valid = 1'b1; bus.req0_op = ALU_SEL_MULT; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        total++;
        if (bus.md_en !== 1'b0) begin bad++; $display("FAIL reset_md_en got=%b exp=0", bus.md_en); end
        total++;
        if (bus.md_a !== 32'h0 || bus.md_b !== 32'h0 || bus.md_sign !== 1'b0 || bus.md_is_div !== 1'b0) begin
            bad++; $display("FAIL reset_md_bus got=%h/%h/%b/%b exp=0", bus.md_a, bus.md_b, bus.md_sign, bus.md_is_div);
        end
        check_arch("reset");
        clear_req();
        rst = 1'b1;
    endtask

    task automatic test_mult();
        ref_apply(0, 1'b1, ALU_SEL_MULT, 32'hFFFF_FFFF, 32'd2);
        run_bundle(1'b1, ALU_SEL_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, ALU_SEL_NOP, 0, 0, 4);
        total++;
        if (r_stall != 5) begin bad++; $display("FAIL mult_stall got=%0d exp=5", r_stall); end
        total++;
        if (r_sign !== 1'b1 || r_div !== 1'b0) begin bad++; $display("FAIL mult_ctl sign=%b div=%b exp sign=1 div=0", r_sign, r_div); end
        check_arch("mult");
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_const got=%h_%h exp=ffffffff_fffffffe", hi, lo); end
    endtask

    task automatic test_back_to_back();
        ref_apply(0, 1'b1, ALU_SEL_DIVU, 32'd100, 32'd7);
        ref_apply(1, 1'b1, ALU_SEL_MUL, 32'd3, 32'd5);
        run_bundle(1'b1, ALU_SEL_DIVU, 32'd100, 32'd7, 1'b1, ALU_SEL_MUL, 32'd3, 32'd5, 3);
        total++;
        if (r_stall != 8) begin bad++; $display("FAIL b2b_stall got=%0d exp=8", r_stall); end
        total++;
        // one md_en-low cycle in IDLE plus exactly one in GAP
        if (r_en_low != 2) begin bad++; $display("FAIL b2b_gap en_low got=%0d exp=2", r_en_low); end
        total++;
        if (r_sign !== 1'b0 || r_div !== 1'b1) begin bad++; $display("FAIL b2b_ctl sign=%b div=%b exp sign=0 div=1", r_sign, r_div); end
        check_arch("b2b");
        total++;
        if (hi !== 32'd2 || lo !== 32'd14 || mul_res1 !== 32'd15) begin
            bad++; $display("FAIL b2b_const got=%0d/%0d/%0d exp=2/14/15", hi, lo, mul_res1);
        end
    endtask

    task automatic test_mt();
        ref_apply(0, 1'b1, ALU_SEL_MTHI, 32'hA, 0);
        ref_apply(1, 1'b1, ALU_SEL_MTLO, 32'hB, 0);
        run_bundle(1'b1, ALU_SEL_MTHI, 32'hA, 0, 1'b1, ALU_SEL_MTLO, 32'hB, 0, 2);
        total++;
        if (r_stall != 0) begin bad++; $display("FAIL mt_stall got=%0d exp=0", r_stall); end
        check_arch("mt");
        // same register from both slots: younger wins
        ref_apply(0, 1'b1, ALU_SEL_MTLO, 32'h11, 0);
        ref_apply(1, 1'b1, ALU_SEL_MTLO, 32'h22, 0);
        run_bundle(1'b1, ALU_SEL_MTLO, 32'h11, 0, 1'b1, ALU_SEL_MTLO, 32'h22, 0, 2);
        check_arch("mt_same");
    endtask

    task automatic test_suppress();
        ref_apply(0, 1'b1, ALU_SEL_MTHI, 32'h1, 0);
        ref_apply(1, 1'b1, ALU_SEL_DIV, 32'hFFFF_FFF9, 32'd2);
        run_bundle(1'b1, ALU_SEL_MTHI, 32'h1, 0, 1'b1, ALU_SEL_DIV, 32'hFFFF_FFF9, 32'd2, 2);
        total++;
        if (r_stall != 3) begin bad++; $display("FAIL supp_stall got=%0d exp=3", r_stall); end
        check_arch("supp");
        total++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL supp_const got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
    endtask

    task automatic test_flush();
        logic seen_gap, seen_en, hit;
        ref_apply(0, 1'b1, ALU_SEL_DIVU, 32'd100, 32'd7);
        @(negedge clk);
        unit_lat = 3;
        bus.req0_valid = 1'b1; bus.req0_op = ALU_SEL_DIVU; bus.req0_a = 32'd100; bus.req0_b = 32'd7;
        bus.req1_valid = 1'b1; bus.req1_op = ALU_SEL_MULT; bus.req1_a = 32'd5;   bus.req1_b = 32'd6;
        seen_gap = 1'b0; seen_en = 1'b0; hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.md_en === 1'b1) seen_en = 1'b1;
            else if (seen_en && stall_req === 1'b1) seen_gap = 1'b1;
            if (seen_gap && bus.md_en === 1'b1 && bus.md_ready === 1'b1) begin
                flush = 1'b1;
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!hit) begin bad++; $display("FAIL flush_reach never saw slot1 md_ready"); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++;
        if (bus.md_en !== 1'b0) begin bad++; $display("FAIL flush_md_en got=%b exp=0", bus.md_en); end
        clear_req();
        #1;
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL flush_idle stall got=%b exp=0", stall_req); end
        @(negedge clk);
        #1;
        check_arch("flush");
    endtask

    task automatic test_random();
        alu_sel_t pool [8] = '{ALU_SEL_MULT, ALU_SEL_MULTU, ALU_SEL_DIV, ALU_SEL_DIVU,
                               ALU_SEL_MUL, ALU_SEL_MTHI, ALU_SEL_MTLO, ALU_SEL_ADD};
        for (int n = 0; n < 40; n++) begin
            logic        v0, v1;
            alu_sel_t    o0, o1;
            logic [31:0] a0, b0, a1, b1;
            int          lat, es;
            v0 = 1'($urandom); v1 = 1'($urandom);
            o0 = pool[$urandom_range(0, 7)]; o1 = pool[$urandom_range(0, 7)];
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            b1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            if (b0 == 0) b0 = 32'd1;
            if (b1 == 0) b1 = 32'd1;
            lat = $urandom_range(1, 4);
            es  = exp_stall(v0 && tb_mc(o0), v1 && tb_mc(o1), lat);
            ref_apply(0, v0, o0, a0, b0);
            ref_apply(1, v1, o1, a1, b1);
            run_bundle(v0, o0, a0, b0, v1, o1, a1, b1, lat);
            total++;
            if (r_stall != es) begin
                bad++;
                $display("FAIL rnd%0d_stall got=%0d exp=%0d ops=%h/%h v=%b%b", n, r_stall, es, o0, o1, v0, v1);
            end
            check_arch($sformatf("rnd%0d", n));
        end
    endtask

    initial begin
        clear_req();
        bus.md_ready = 1'b0; bus.md_hi = '0; bus.md_lo = '0;
        test_reset();
        test_mult();
        test_back_to_back();
        test_mt();
        test_suppress();
        test_flush();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
